// File: rtl/countdown_timer_if.sv
// countdown_timer_if: control/status bundle between game control and the MM:SS countdown timer.
`default_nettype none

interface countdown_timer_if;
  logic        load;
  logic [7:0]  load_min;
  logic [7:0]  load_sec;
  logic        start;
  logic        pause;
  logic [15:0] time_bcd;
  logic        running;
  logic        time_up;
  logic        expire_pulse;
  logic [6:0]  hex0;
  logic [6:0]  hex1;
  logic [6:0]  hex2;
  logic [6:0]  hex3;

  modport master (
    output load, load_min, load_sec, start, pause,
    input  time_bcd, running, time_up, expire_pulse, hex0, hex1, hex2, hex3
  );

  modport slave (
    input  load, load_min, load_sec, start, pause,
    output time_bcd, running, time_up, expire_pulse, hex0, hex1, hex2, hex3
  );
endinterface

`default_nettype wire

// File: rtl/countdown_timer.sv
// countdown_timer: loadable BCD MM:SS round timer with 1 Hz prescaler and active-low 7-seg outputs.
// Optional macro BLINK_ON_EXPIRE_EN blanks the display on alternate prescaler wraps while expired.
`default_nettype none

module countdown_timer #(
  parameter logic [27:0] TICK_COUNT = 28'd49_999_999
) (
  input  wire                clk,
  input  wire                resetn,
  countdown_timer_if.slave   bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_PAUSE   = 2'd2;
  localparam logic [1:0] ST_EXPIRED = 2'd3;

  logic [1:0]  state_q,  state_d;
  logic [15:0] time_q,   time_d;
  logic [27:0] presc_q,  presc_d;
  logic        expire_q, expire_d;
  logic [15:0] time_dec;
`ifdef BLINK_ON_EXPIRE_EN
  logic        blink_q,  blink_d;
`endif

  function automatic logic [7:0] clamp_field(input logic [7:0] f);
    return (f[7:4] > 4'd5 || f[3:0] > 4'd9) ? 8'h59 : f;
  endfunction

  function automatic logic [15:0] dec_time(input logic [15:0] t);
    logic [15:0] r;
    r = t;
    if (t[3:0] != 4'd0) begin
      r[3:0] = t[3:0] - 4'd1;
    end else if (t[7:4] != 4'd0) begin
      r[7:4] = t[7:4] - 4'd1;
      r[3:0] = 4'd9;
    end else if (t[15:8] != 8'h00) begin
      r[7:0] = 8'h59;
      if (t[11:8] != 4'd0) begin
        r[11:8] = t[11:8] - 4'd1;
      end else begin
        r[15:12] = t[15:12] - 4'd1;
        r[11:8]  = 4'd9;
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h18;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  assign time_dec = dec_time(time_q);

  always_comb begin
    state_d  = state_q;
    time_d   = time_q;
    presc_d  = presc_q;
    expire_d = 1'b0;
`ifdef BLINK_ON_EXPIRE_EN
    blink_d  = blink_q;
`endif
    if (bus.load) begin
      time_d  = {clamp_field(bus.load_min), clamp_field(bus.load_sec)};
      state_d = ST_IDLE;
      presc_d = TICK_COUNT;
`ifdef BLINK_ON_EXPIRE_EN
      blink_d = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start && time_q != 16'h0000) begin
            state_d = ST_RUN;
            presc_d = TICK_COUNT;
          end
        end
        ST_PAUSE: begin
          if (bus.start) state_d = ST_RUN;
        end
        ST_RUN: begin
          // A pause cycle freezes the prescaler before it can tick.
          if (bus.start) begin
            state_d = ST_RUN;
          end
          if (bus.pause && !bus.start) begin
            state_d = ST_PAUSE;
          end else if (presc_q == 28'd0) begin
            presc_d = TICK_COUNT;
            time_d  = time_dec;
            if (time_dec == 16'h0000) begin
              state_d  = ST_EXPIRED;
              expire_d = 1'b1;
            end
          end else begin
            presc_d = presc_q - 28'd1;
          end
        end
        default: begin
`ifdef BLINK_ON_EXPIRE_EN
          if (presc_q == 28'd0) begin
            presc_d = TICK_COUNT;
            blink_d = ~blink_q;
          end else begin
            presc_d = presc_q - 28'd1;
          end
`endif
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      time_q   <= 16'h0000;
      presc_q  <= TICK_COUNT;
      expire_q <= 1'b0;
`ifdef BLINK_ON_EXPIRE_EN
      blink_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      time_q   <= time_d;
      presc_q  <= presc_d;
      expire_q <= expire_d;
`ifdef BLINK_ON_EXPIRE_EN
      blink_q  <= blink_d;
`endif
    end
  end

  assign bus.time_bcd     = time_q;
  assign bus.running      = (state_q == ST_RUN);
  assign bus.time_up      = (state_q == ST_EXPIRED);
  assign bus.expire_pulse = expire_q;

`ifdef BLINK_ON_EXPIRE_EN
  assign bus.hex0 = blink_q ? 7'h7F : seg7(time_q[3:0]);
  assign bus.hex1 = blink_q ? 7'h7F : seg7(time_q[7:4]);
  assign bus.hex2 = blink_q ? 7'h7F : seg7(time_q[11:8]);
  assign bus.hex3 = blink_q ? 7'h7F : seg7(time_q[15:12]);
`else
  assign bus.hex0 = seg7(time_q[3:0]);
  assign bus.hex1 = seg7(time_q[7:4]);
  assign bus.hex2 = seg7(time_q[11:8]);
  assign bus.hex3 = seg7(time_q[15:12]);
`endif

endmodule

`default_nettype wire

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed scenarios plus randomized traffic checked against a seconds-based model.
`default_nettype none

module tb_countdown_timer;
  localparam int TICK = 3;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   total = 0;
  int   bad = 0;

  countdown_timer_if ifc();

  countdown_timer #(.TICK_COUNT(28'd3)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (ifc.slave)
  );

  always #5 clk = ~clk;

  // Reference model: remaining time as plain seconds, clocks left until next tick.
  typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_EXP} mstate_t;
  mstate_t m_st;
  int      m_secs;
  int      m_cnt;
  bit      m_pulse;
  bit      m_blink;

  logic [6:0] seg_tab [10];
  initial begin
    seg_tab[0] = 7'h40; seg_tab[1] = 7'h79; seg_tab[2] = 7'h24; seg_tab[3] = 7'h30;
    seg_tab[4] = 7'h19; seg_tab[5] = 7'h12; seg_tab[6] = 7'h02; seg_tab[7] = 7'h78;
    seg_tab[8] = 7'h00; seg_tab[9] = 7'h18;
  end

  function automatic int clampf(input logic [7:0] v);
    if (v[7:4] > 4'd5 || v[3:0] > 4'd9) return 59;
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [15:0] to_bcd(input int s);
    int mm, ss;
    mm = s / 60;
    ss = s % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic logic [27:0] exp_hex(input int s, input bit blank);
    logic [15:0] b;
    b = to_bcd(s);
    if (blank) return {4{7'h7F}};
    return {seg_tab[b[15:12]], seg_tab[b[11:8]], seg_tab[b[7:4]], seg_tab[b[3:0]]};
  endfunction

  task automatic model_reset();
    m_st = M_IDLE; m_secs = 0; m_cnt = TICK; m_pulse = 0; m_blink = 0;
  endtask

  task automatic model_step(input bit ld, input logic [7:0] lm, input logic [7:0] ls,
                            input bit st, input bit ps);
    m_pulse = 0;
    if (ld) begin
      m_secs = clampf(lm) * 60 + clampf(ls);
      m_st = M_IDLE; m_cnt = TICK; m_blink = 0;
    end else if (m_st == M_IDLE) begin
      if (st && m_secs > 0) begin m_st = M_RUN; m_cnt = TICK; end
    end else if (m_st == M_PAUSE) begin
      if (st) m_st = M_RUN;
    end else if (m_st == M_RUN) begin
      if (ps && !st) m_st = M_PAUSE;
      else if (m_cnt == 0) begin
        m_cnt = TICK;
        m_secs = m_secs - 1;
        if (m_secs == 0) begin m_st = M_EXP; m_pulse = 1; end
      end else m_cnt = m_cnt - 1;
    end else begin
`ifdef BLINK_ON_EXPIRE_EN
      if (m_cnt == 0) begin m_cnt = TICK; m_blink = ~m_blink; end
      else m_cnt = m_cnt - 1;
`endif
    end
  endtask

  task automatic cyc(input bit ld, input logic [7:0] lm, input logic [7:0] ls,
                     input bit st, input bit ps);
    ifc.load = ld; ifc.load_min = lm; ifc.load_sec = ls; ifc.start = st; ifc.pause = ps;
    @(posedge clk);
    model_step(ld, lm, ls, st, ps);
    #1;
    ifc.load = 1'b0; ifc.start = 1'b0; ifc.pause = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 8'h00, 8'h00, 0, 0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (ifc.time_bcd !== 16'h0000) begin bad++; $display("FAIL reset_time got=%h exp=0000", ifc.time_bcd); end
    total++; if ({ifc.running, ifc.time_up, ifc.expire_pulse} !== 3'b000) begin bad++;
      $display("FAIL reset_flags got=%b exp=000", {ifc.running, ifc.time_up, ifc.expire_pulse}); end
    total++; if ({ifc.hex3, ifc.hex2, ifc.hex1, ifc.hex0} !== {4{7'h40}}) begin bad++;
      $display("FAIL reset_hex got=%h exp=%h", {ifc.hex3, ifc.hex2, ifc.hex1, ifc.hex0}, {4{7'h40}}); end
  endtask

  task automatic test_minute_borrow();
    cyc(1, 8'h01, 8'h00, 0, 0);
    cyc(0, 8'h00, 8'h00, 1, 0);
    total++; if (ifc.running !== 1'b1) begin bad++; $display("FAIL borrow_running got=%b exp=1", ifc.running); end
    idle(3);
    total++; if (ifc.time_bcd !== 16'h0100) begin bad++; $display("FAIL borrow_early got=%h exp=0100", ifc.time_bcd); end
    idle(1);
    total++; if (ifc.time_bcd !== 16'h0059) begin bad++; $display("FAIL borrow_time got=%h exp=0059", ifc.time_bcd); end
    total++; if ({ifc.hex3, ifc.hex2, ifc.hex1, ifc.hex0} !== {7'h40, 7'h40, 7'h12, 7'h18}) begin bad++;
      $display("FAIL borrow_hex got=%h exp=%h", {ifc.hex3, ifc.hex2, ifc.hex1, ifc.hex0}, {7'h40, 7'h40, 7'h12, 7'h18}); end
  endtask

  task automatic test_expire();
    int pulses;
    cyc(1, 8'h00, 8'h02, 0, 0);
    cyc(0, 8'h00, 8'h00, 1, 0);
    idle(4);
    total++; if (ifc.time_bcd !== 16'h0001) begin bad++; $display("FAIL expire_mid got=%h exp=0001", ifc.time_bcd); end
    idle(4);
    total++; if (ifc.time_bcd !== 16'h0000) begin bad++; $display("FAIL expire_time got=%h exp=0000", ifc.time_bcd); end
    total++; if ({ifc.time_up, ifc.running, ifc.expire_pulse} !== 3'b101) begin bad++;
      $display("FAIL expire_flags got=%b exp=101", {ifc.time_up, ifc.running, ifc.expire_pulse}); end
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      idle(1);
      if (ifc.expire_pulse === 1'b1) pulses++;
      total++; if (ifc.time_bcd !== 16'h0000 || ifc.time_up !== 1'b1) begin bad++;
        $display("FAIL expire_hold cyc=%0d time=%h up=%b exp=0000/1", i, ifc.time_bcd, ifc.time_up); end
    end
    total++; if (pulses != 0) begin bad++; $display("FAIL expire_pulse_width extra=%0d exp=0", pulses); end
  endtask

  task automatic test_pause_resume();
    cyc(1, 8'h00, 8'h10, 0, 0);
    cyc(0, 8'h00, 8'h00, 1, 0);
    idle(2);
    cyc(0, 8'h00, 8'h00, 0, 1);
    total++; if (ifc.running !== 1'b0) begin bad++; $display("FAIL pause_running got=%b exp=0", ifc.running); end
    idle(50);
    total++; if (ifc.time_bcd !== 16'h0010) begin bad++; $display("FAIL pause_hold got=%h exp=0010", ifc.time_bcd); end
    cyc(0, 8'h00, 8'h00, 1, 0);
    idle(1);
    total++; if (ifc.time_bcd !== 16'h0010) begin bad++; $display("FAIL resume_early got=%h exp=0010", ifc.time_bcd); end
    idle(1);
    total++; if (ifc.time_bcd !== 16'h0009) begin bad++; $display("FAIL resume_time got=%h exp=0009", ifc.time_bcd); end
  endtask

  task automatic test_clamp();
    cyc(1, 8'h9A, 8'h61, 0, 0);
    total++; if (ifc.time_bcd !== 16'h5959) begin bad++; $display("FAIL clamp_both got=%h exp=5959", ifc.time_bcd); end
    cyc(1, 8'h12, 8'h7A, 0, 0);
    total++; if (ifc.time_bcd !== 16'h1259) begin bad++; $display("FAIL clamp_sec got=%h exp=1259", ifc.time_bcd); end
    cyc(1, 8'h00, 8'h00, 0, 0);
    cyc(0, 8'h00, 8'h00, 1, 0);
    total++; if (ifc.running !== 1'b0) begin bad++; $display("FAIL zero_start got=%b exp=0", ifc.running); end
  endtask

  task automatic test_reset_midrun();
    cyc(1, 8'h00, 8'h05, 0, 0);
    cyc(0, 8'h00, 8'h00, 1, 0);
    idle(3);
    do_reset();
    total++; if ({ifc.time_bcd, ifc.running, ifc.time_up, ifc.expire_pulse} !== 19'd0) begin bad++;
      $display("FAIL midrun_reset got=%h/%b%b%b exp=0000/000", ifc.time_bcd, ifc.running, ifc.time_up, ifc.expire_pulse); end
    cyc(0, 8'h00, 8'h00, 1, 0);
    idle(4);
    total++; if (ifc.running !== 1'b0 || ifc.time_bcd !== 16'h0000) begin bad++;
      $display("FAIL midrun_start run=%b time=%h exp=0/0000", ifc.running, ifc.time_bcd); end
  endtask

  task automatic test_load_tick();
    cyc(1, 8'h00, 8'h05, 0, 0);
    cyc(0, 8'h00, 8'h00, 1, 0);
    idle(3);
    cyc(1, 8'h00, 8'h30, 0, 0);
    total++; if (ifc.time_bcd !== 16'h0030 || ifc.running !== 1'b0) begin bad++;
      $display("FAIL load_tick time=%h run=%b exp=0030/0", ifc.time_bcd, ifc.running); end
    idle(6);
    total++; if (ifc.time_bcd !== 16'h0030) begin bad++; $display("FAIL load_tick_hold got=%h exp=0030", ifc.time_bcd); end
  endtask

  task automatic test_random();
    bit ld, st, ps;
    logic [7:0] lm, ls;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      ld = ($urandom_range(0, 39) == 0);
      st = ($urandom_range(0, 7) == 0);
      ps = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) begin
        lm = 8'($urandom); ls = 8'($urandom);
      end else begin
        lm = 8'h00; ls = {4'($urandom_range(0, 1)), 4'($urandom_range(0, 9))};
      end
      cyc(ld, lm, ls, st, ps);
      total++;
      if (ifc.time_bcd !== to_bcd(m_secs) || ifc.running !== (m_st == M_RUN) ||
          ifc.time_up !== (m_st == M_EXP) || ifc.expire_pulse !== m_pulse ||
          {ifc.hex3, ifc.hex2, ifc.hex1, ifc.hex0} !== exp_hex(m_secs, m_blink)) begin
        bad++;
        $display("FAIL random cyc=%0d got time=%h run=%b up=%b pulse=%b exp time=%h run=%b up=%b pulse=%b",
                 i, ifc.time_bcd, ifc.running, ifc.time_up, ifc.expire_pulse,
                 to_bcd(m_secs), (m_st == M_RUN), (m_st == M_EXP), m_pulse);
      end
    end
  endtask

  initial begin
    ifc.load = 1'b0; ifc.load_min = 8'h00; ifc.load_sec = 8'h00;
    ifc.start = 1'b0; ifc.pause = 1'b0;
    model_reset();
    test_reset();
    test_minute_borrow();
    test_expire();
    test_pause_resume();
    test_clamp();
    test_reset_midrun();
    test_load_tick();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
